uart_rx_deframer: RTL and testbench

//   Serial receive front-end of the APB UART. Synchronises the RXD pin, detects and validates the start bit,
//   and samples 5..8 data bits, optional parity and one stop bit at mid-bit. Delivers each byte with
//   PE/FE/BI status over a valid/ready handshake to the RX FIFO/LSR logic of the UART core.

---
 rtl/uart_rx_deframer.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: RXD synchroniser, start-bit validation, mid-bit sampling of 5..8 data bits,
// optional parity and one stop bit, delivered over valid/ready. Build macro: UART_RX_MAJORITY_EN.
module uart_rx_deframer #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             rxd_i,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       lcr_wls,
    input  logic             lcr_pen,
    input  logic             lcr_eps,
    output logic [7:0]       rx_data,
    output logic             rx_pe,
    output logic             rx_fe,
    output logic             rx_bi,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_oe,
    output logic             rx_busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_prev;
    state_t                 r_state;
    logic [DIV_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       r_div;
    logic [1:0]             r_wls;
    logic                   r_pen;
    logic                   r_eps;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic                   r_pe;
    logic                   r_done;
    logic [7:0]             r_done_data;
    logic                   r_done_pe;
    logic                   r_done_fe;
    logic                   r_done_bi;

    logic                   w_rxd;
    logic                   w_edge;
    logic                   w_take;
    logic                   w_bit;
    logic                   w_cnt_wrap;
    logic [DIV_W-1:0]       w_mid;

    assign w_rxd      = r_sync[SYNC_STAGES-1];
    assign w_edge     = r_rxd_prev & ~w_rxd;
    assign w_mid      = r_div >> 1;
    assign w_cnt_wrap = (r_cnt == r_div - DIV_W'(1));

    // NOTE: reset is synchronous, so it is sampled inside the clocked block like any other input.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_sync     <= '1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rxd_i};
            r_rxd_prev <= w_rxd;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_s_early;
    logic r_s_mid;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_s_early <= 1'b1;
            r_s_mid   <= 1'b1;
        end else begin
            if (r_cnt == w_mid - DIV_W'(1)) r_s_early <= w_rxd;
            if (r_cnt == w_mid)             r_s_mid   <= w_rxd;
        end
    end

    // Decision one cycle after mid, once all three samples are available.
    assign w_take = (r_state != S_IDLE) && (r_cnt == w_mid + DIV_W'(1));
    assign w_bit  = (r_s_early & r_s_mid) | (r_s_early & w_rxd) | (r_s_mid & w_rxd);
`else
    assign w_take = (r_state != S_IDLE) && (r_cnt == w_mid);
    assign w_bit  = w_rxd;
`endif

    // NOTE: all state updates use non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div       <= '0;
            r_wls       <= '0;
            r_pen       <= 1'b0;
            r_eps       <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_pe        <= 1'b0;
            r_done      <= 1'b0;
            r_done_data <= '0;
            r_done_pe   <= 1'b0;
            r_done_fe   <= 1'b0;
            r_done_bi   <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) r_cnt <= w_cnt_wrap ? '0 : r_cnt + DIV_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_edge && (divisor >= DIV_W'(4))) begin
                        r_state  <= S_START;
                        r_cnt    <= '0;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                        r_par    <= 1'b0;
                        r_pe     <= 1'b0;
                        r_div    <= divisor;
                        r_wls    <= lcr_wls;
                        r_pen    <= lcr_pen;
                        r_eps    <= lcr_eps;
                        rx_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_take) begin
                        r_state <= w_bit ? S_IDLE : S_DATA;
                        rx_busy <= ~w_bit;
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        r_shift[r_bitcnt] <= w_bit;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        if (r_bitcnt == {1'b0, r_wls} + 3'd4) r_state <= r_pen ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (w_take) begin
                        r_par   <= w_bit;
                        r_pe    <= (^r_shift ^ w_bit) != ~r_eps;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Back to IDLE on the stop sample so an immediately following start edge is seen.
                    if (w_take) begin
                        r_done      <= 1'b1;
                        r_done_data <= r_shift;
                        r_done_pe   <= r_pe;
                        r_done_fe   <= ~w_bit;
                        r_done_bi   <= ~w_bit & (r_shift == 8'h00) & (~r_pen | ~r_par);
                        r_state     <= S_IDLE;
                        rx_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_data  <= '0;
            rx_pe    <= 1'b0;
            rx_fe    <= 1'b0;
            rx_bi    <= 1'b0;
            rx_valid <= 1'b0;
            rx_oe    <= 1'b0;
        end else begin
            rx_oe <= 1'b0;
            if (r_done && (!rx_valid || rx_ready)) begin
                rx_data  <= r_done_data;
                rx_pe    <= r_done_pe;
                rx_fe    <= r_done_fe;
                rx_bi    <= r_done_bi;
                rx_valid <= 1'b1;
            end else begin
                // A finished frame with the output still occupied is dropped.
                if (r_done) rx_oe <= 1'b1;
                if (rx_valid && rx_ready) rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: a line driver plus a reference frame model feeding a
// scoreboard queue that is drained by a monitor on every accepted output.
module tb_uart_rx_deframer;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             preset;
    logic             rxd;
    logic [DIV_W-1:0] divisor;
    logic [1:0]       lcr_wls;
    logic             lcr_pen;
    logic             lcr_eps;
    logic [7:0]       rx_data;
    logic             rx_pe, rx_fe, rx_bi, rx_valid, rx_ready, rx_oe, rx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } frame_t;

    frame_t sb[$];
    frame_t exp_f;
    int     n_checks     = 0;
    int     n_errors     = 0;
    int     cyc          = 0;
    int     accept_cyc   = 0;
    int     accept_count = 0;
    int     oe_count     = 0;
    bit     busy_seen    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_deframer #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
        .PCLK     (clk),
        .PRESET   (preset),
        .rxd_i    (rxd),
        .divisor  (divisor),
        .lcr_wls  (lcr_wls),
        .lcr_pen  (lcr_pen),
        .lcr_eps  (lcr_eps),
        .rx_data  (rx_data),
        .rx_pe    (rx_pe),
        .rx_fe    (rx_fe),
        .rx_bi    (rx_bi),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_oe    (rx_oe),
        .rx_busy  (rx_busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic frame_t model(input logic [7:0] d, input int nbits, input logic pen,
                                     input logic eps, input logic par, input logic stop);
        frame_t     f;
        int         ones;
        logic [7:0] mask;
        mask   = 8'((1 << nbits) - 1);
        f.data = d & mask;
        ones   = $countones(f.data);
        if (pen) ones += int'(par);
        f.pe   = pen && (eps ? (ones % 2 == 1) : (ones % 2 == 0));
        f.fe   = !stop;
        f.bi   = !stop && (f.data == 8'h00) && (!pen || !par);
        return f;
    endfunction

    // Monitor: every accepted output must match the oldest expected frame.
    always @(negedge clk) begin
        if (!preset) begin
            if (rx_oe) oe_count++;
            if (rx_busy) busy_seen = 1'b1;
            if (rx_valid && rx_ready) begin
                accept_count++;
                accept_cyc = cyc;
                check("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_f = sb.pop_front();
                    check("frame", 32'({rx_data, rx_pe, rx_fe, rx_bi}), 32'(exp_f));
                end
            end
        end
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_bit(input logic v, input int div, input bit glitch);
        for (int i = 0; i < div; i++) begin
            rxd = (glitch && (i == div / 2 + 1)) ? ~v : v;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit glitch);
        int div;
        div = int'(divisor);
        send_bit(1'b0, div, glitch);
        for (int i = 0; i < int'(lcr_wls) + 5; i++) send_bit(d[i], div, glitch);
        if (lcr_pen) send_bit(par, div, glitch);
        send_bit(stop, div, glitch);
        rxd = 1'b1;
    endtask

    task automatic push_send(input logic [7:0] d, input logic par, input logic stop, input bit glitch);
        sb.push_back(model(d, int'(lcr_wls) + 5, lcr_pen, lcr_eps, par, stop));
        send_frame(d, par, stop, glitch);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n0, low_at;
        preset   = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        divisor  = 16'd434;
        lcr_wls  = 2'b11;
        lcr_pen  = 1'b0;
        lcr_eps  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({rx_data, rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy}), 32'd0);
        @(posedge clk); #1;
        preset = 1'b0;
        idle(5);

        // 8N1 at divisor 434, with start-edge-to-output latency window.
        c0 = cyc;
        push_send(8'h6B, 1'b0, 1'b1, 1'b0);
        wait_drain("t1", 50);
        check("t1_latency", 32'((accept_cyc - c0 >= 9 * 434 + 217) && (accept_cyc - c0 <= 9 * 434 + 217 + 8)), 32'd1);

        // Parity, odd: 0xA7 with parity 1 is an error, with parity 0 is clean.
        divisor = 16'd16;
        lcr_pen = 1'b1;
        lcr_eps = 1'b0;
        idle(4);
        push_send(8'hA7, 1'b1, 1'b1, 1'b0);
        push_send(8'hA7, 1'b0, 1'b1, 1'b0);
        wait_drain("t2", 50);

        // Back-to-back frames over other word lengths and even/odd parity.
        for (int k = 0; k < 4; k++) begin
            lcr_wls = 2'(k);
            lcr_eps = 1'(k);
            push_send(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        wait_drain("t2b", 50);

        // Held-low line: exactly one break frame.
        lcr_wls = 2'b11;
        lcr_pen = 1'b0;
        idle(4);
        n0 = accept_count;
        sb.push_back(model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0));
        send_bit(1'b0, 12 * 16, 1'b0);
        idle(3 * 16);
        wait_drain("t3", 50);
        check("t3_one_frame", 32'(accept_count - n0), 32'd1);

        // 100-cycle glitch at divisor 434: false start, no output.
        divisor = 16'd434;
        idle(4);
        n0        = accept_count;
        busy_seen = 1'b0;
        low_at    = -1;
        for (int i = 0; i < 600; i++) begin
            rxd = (i < 100) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (busy_seen && !rx_busy && low_at < 0) low_at = i + 1;
        end
        check("t4_busy_seen", 32'(busy_seen), 32'd1);
        check("t4_busy_drop", 32'((low_at >= 217) && (low_at <= 226)), 32'd1);
        check("t4_no_frame", 32'(accept_count - n0), 32'd0);

        // Overrun: second frame dropped while the first is held.
        divisor  = 16'd16;
        rx_ready = 1'b0;
        n0       = oe_count;
        push_send(8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        idle(8);
        check("t5_valid_held", 32'(rx_valid), 32'd1);
        check("t5_data_held", 32'(rx_data), 32'h55);
        check("t5_oe_pulses", 32'(oe_count - n0), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid_drop", 32'(rx_valid), 32'd0);
        wait_drain("t5", 10);

        // Five-bit word, then a reset in the middle of the next frame.
        lcr_wls = 2'b00;
        idle(4);
        push_send(8'h15, 1'b0, 1'b1, 1'b0);
        wait_drain("t6", 50);
        n0 = accept_count;
        send_bit(1'b0, 16, 1'b0);
        send_bit(1'b1, 16, 1'b0);
        send_bit(1'b0, 8, 1'b0);
        preset = 1'b1;
        rxd    = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t6_reset_outputs", 32'({rx_data, rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy}), 32'd0);
        @(posedge clk); #1;
        preset = 1'b0;
        idle(4 * 16 * 8);
        check("t6_no_frame", 32'(accept_count - n0), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        push_send(8'h15, 1'b0, 1'b1, 1'b1);
        wait_drain("t6_glitch", 50);
`endif

        // Divisor boundary: 4 is the smallest accepted, 3 never leaves IDLE.
        divisor = 16'd4;
        lcr_wls = 2'b11;
        push_send(8'hC3, 1'b0, 1'b1, 1'b0);
        wait_drain("div4", 50);
        divisor   = 16'd3;
        n0        = accept_count;
        idle(4);
        busy_seen = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        idle(40);
        check("div3_busy", 32'(busy_seen), 32'd0);
        check("div3_no_frame", 32'(accept_count - n0), 32'd0);

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
